// File: rtl/sel_pipe_mux.sv
// Channel-select mux with one registered, back-pressured output stage.
// Optional round-robin selection is enabled by defining MUXSEL_RR_EN.
module sel_pipe_mux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef MUXSEL_RR_EN
    input  logic                        rr_mode,
`endif
    input  logic [SEL_W-1:0]            addr,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_chan,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int unsigned CMP_W = SEL_W + 1;

    logic [WIDTH-1:0]    data_q, data_d;
    logic [SEL_W-1:0]    chan_q, chan_d;
    logic                valid_q, valid_d;

    logic                can_load;
    logic                addr_hit;
    logic                sel_hit;
    logic [SEL_W-1:0]    sel;
    logic [CHANNELS-1:0] grant;
    logic [WIDTH-1:0]    sel_data;
    logic                xfer;

    // Addresses at or beyond CHANNELS select nothing.
    assign addr_hit = ({1'b0, addr} < CMP_W'(CHANNELS));

`ifdef MUXSEL_RR_EN
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] rr_sel;
    logic             rr_hit;

    // First valid channel at or above ptr, else first valid channel below it.
    always_comb begin : rr_search
        logic             hi_hit;
        logic             lo_hit;
        logic [SEL_W-1:0] hi_sel;
        logic [SEL_W-1:0] lo_sel;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_sel = '0;
        lo_sel = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!hi_hit && in_valid[k] && (SEL_W'(k) >= ptr_q)) begin
                hi_hit = 1'b1;
                hi_sel = SEL_W'(k);
            end
            if (!lo_hit && in_valid[k]) begin
                lo_hit = 1'b1;
                lo_sel = SEL_W'(k);
            end
        end
        rr_hit = hi_hit || lo_hit;
        rr_sel = hi_hit ? hi_sel : lo_sel;
    end

    always_comb begin
        if (rr_mode) begin
            sel_hit = rr_hit;
            sel     = rr_sel;
        end else begin
            sel_hit = addr_hit;
            sel     = addr;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && rr_mode) begin
            ptr_d = (sel == LAST_CH) ? '0 : sel + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign sel_hit = addr_hit;
    assign sel     = addr;
`endif

    assign can_load = !rst && !flush && (!valid_q || out_ready);

    // One-hot grant and selected payload.
    always_comb begin
        grant    = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == sel) begin
                grant[k] = sel_hit;
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = can_load ? grant : '0;
    assign xfer     = |(in_ready & in_valid);

    // Output stage: flush clears, transfer loads, a consumed word without refill empties.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        if (flush) begin
            data_d  = '0;
            chan_d  = '0;
            valid_d = 1'b0;
        end else if (xfer) begin
            data_d  = sel_data;
            chan_d  = sel;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Scoreboard bench for sel_pipe_mux; exercises round-robin too when MUXSEL_RR_EN is defined.
module tb_sel_pipe_mux;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [SW-1:0] c;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             rr_mode;
    logic [SW-1:0]    addr;
    logic [CH*W-1:0]  in_data;
    logic [CH-1:0]    in_valid;
    logic [CH-1:0]    in_ready;
    logic             flush;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_chan;
    logic             out_valid;
    logic             out_ready;

    logic [SW-1:0]    addr3;
    logic [3*W-1:0]   in_data3;
    logic [2:0]       in_valid3;
    logic [2:0]       in_ready3;
    logic [W-1:0]     out_data3;
    logic [SW-1:0]    out_chan3;
    logic             out_valid3;

    int     n_vec = 0;
    int     n_err = 0;
    word_t  sb[$];
    word_t  m_word;
    logic   m_valid;
    logic   m_init;
    logic [SW-1:0] m_ptr;

    always #5 clk = ~clk;

    sel_pipe_mux #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUXSEL_RR_EN
        .rr_mode   (rr_mode),
`endif
        .addr      (addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    sel_pipe_mux #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
`ifdef MUXSEL_RR_EN
        .rr_mode   (1'b0),
`endif
        .addr      (addr3),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .flush     (1'b0),
        .out_data  (out_data3),
        .out_chan  (out_chan3),
        .out_valid (out_valid3),
        .out_ready (1'b1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference selection: scan cyclically from the pointer, or decode addr.
    task automatic model_sel(output logic hit, output logic [SW-1:0] sel);
        hit = 1'b0;
        sel = '0;
        if (rr_mode) begin
            for (int i = 0; i < CH; i++) begin
                int idx;
                idx = (int'(m_ptr) + i) % CH;
                if (!hit && in_valid[idx]) begin
                    hit = 1'b1;
                    sel = SW'(idx);
                end
            end
        end else if (int'(addr) < CH) begin
            hit = 1'b1;
            sel = addr;
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, updates model, advances one cycle.
    task automatic cycle();
        logic          hit;
        logic [SW-1:0] sel;
        logic          can_load;
        logic          xfer;
        logic [CH-1:0] exp_rdy;
        word_t         got;
        word_t         w;
        #1;
        model_sel(hit, sel);
        can_load = !rst && !flush && (!m_valid || out_ready);
        exp_rdy  = '0;
        if (can_load && hit) exp_rdy[sel] = 1'b1;
        xfer = |(exp_rdy & in_valid);
        got  = {out_data, out_chan};
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (m_init) begin
            check_eq("out_valid", 64'(out_valid), 64'(m_valid));
            check_eq("out_word", 64'(got), 64'(m_word));
        end
        if (rst) begin
            sb.delete();
            m_valid = 1'b0;
            m_word  = '0;
            m_ptr   = '0;
            m_init  = 1'b1;
        end else if (flush) begin
            sb.delete();
            m_valid = 1'b0;
            m_word  = '0;
        end else begin
            if (m_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_empty", 64'(1), 64'(0));
                end else begin
                    w = sb.pop_front();
                    check_eq("sb_pop", 64'(got), 64'(w));
                end
                m_valid = 1'b0;
            end
            if (xfer) begin
                m_word  = {in_data[int'(sel)*W +: W], sel};
                sb.push_back(m_word);
                m_valid = 1'b1;
                if (rr_mode) m_ptr = (int'(sel) == CH-1) ? '0 : sel + SW'(1);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rr_mode = 1'b0; addr = '0; in_data = '0; in_valid = '0;
        flush = 1'b0; out_ready = 1'b1; m_init = 1'b0; m_valid = 1'b0;
        m_word = '0; m_ptr = '0;
        addr3 = 2'd3; in_data3 = {3{32'hA5A5_0001}}; in_valid3 = 3'b111;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Basic addressed transfer of DEADBEEF on channel 2.
        addr = 2'd2; in_valid = 4'b0100; set_ch(2, 32'hDEAD_BEEF); out_ready = 1'b1;
        cycle();
        in_valid = '0;
        cycle();
        check_eq("req034_chan", 64'(out_chan), 64'(2));
        cycle();

        // Stall for three cycles with a held word of 1.
        addr = 2'd0; set_ch(0, 32'h1); in_valid = 4'b0001;
        cycle();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            addr = SW'(i + 1);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        check_eq("stall_hold", 64'(out_data), 64'(1));
        out_ready = 1'b1; addr = 2'd3; set_ch(3, 32'h3333_0003);
        cycle();
        in_valid = '0;
        cycle();

        // Flush with a valid input pending: nothing accepted, then next word accepted.
        addr = 2'd1; set_ch(1, 32'h1111_0001); in_valid = 4'b0010;
        cycle();
        flush = 1'b1; set_ch(1, 32'h2222_0002);
        cycle();
        flush = 1'b0;
        check_eq("flush_zero", 64'({out_valid, out_data}), 64'(0));
        cycle();
        in_valid = '0;
        cycle();

        // Random traffic in addressed mode with back-pressure, flush and reset.
        for (int i = 0; i < 300; i++) begin
            addr      = SW'($urandom_range(0, CH-1));
            in_valid  = CH'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;

`ifdef MUXSEL_RR_EN
        // Round-robin: all valid, then alternating channels.
        do_reset();
        rr_mode = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_data = {32'h3, 32'h2, 32'h1, 32'h0};
            cycle();
        end
        do_reset();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) cycle();
        // Stalled word with ptr=2 is discarded by reset; next grant from channel 0.
        do_reset();
        in_valid = 4'b0011;
        cycle();
        cycle();
        out_ready = 1'b0; in_valid = 4'b1111;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; out_ready = 1'b1;
        check_eq("rr_rst_valid", 64'(out_valid), 64'(0));
        cycle();
        check_eq("rr_rst_chan", 64'(out_chan), 64'(0));
        for (int i = 0; i < 300; i++) begin
            rr_mode   = ($urandom_range(0, 3) != 0);
            addr      = SW'($urandom_range(0, CH-1));
            in_valid  = CH'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0; flush = 1'b0; rr_mode = 1'b0;
`endif

        // Three-channel instance: addr 3 selects nothing.
        for (int i = 0; i < 3; i++) begin
            check_eq("ch3_in_ready", 64'(in_ready3), 64'(0));
            check_eq("ch3_out_valid", 64'(out_valid3), 64'(0));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sel_pipe_mux.md
SEL_PIPE_MUX -- requirements
Module: sel_pipe_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width per channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels, range 2..2^SEL_W.
REQ-003 SHALL have parameter SEL_W, default 2, width of the channel select.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port addr  input  SEL_W  channel select in addressed mode.
REQ-007 SHALL have port in_data  input  CHANNELS*WIDTH  flattened inputs; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_valid  input  CHANNELS  per-channel valid.
REQ-009 SHALL have port in_ready  output  CHANNELS  per-channel ready, combinational.
REQ-010 SHALL have port flush  input  1  active-high; empties the output stage.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_chan  output  SEL_W  channel index of held word.
REQ-013 SHALL have port out_valid  output  1  output stage holds a word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-015 SHALL have port rr_mode  input  1  1 = round-robin select, 0 = addressed; present only with MUXSEL_RR_EN.

Function
REQ-016 SHALL implement one registered output stage; latency input accept -> out_valid is exactly 1 cycle.
REQ-017 SHALL define can_load = !flush && (!out_valid || out_ready).
REQ-018 Addressed mode: sel = addr; if addr >= CHANNELS, no channel is selected, all in_ready = 0.
REQ-019 SHALL drive in_ready[k] = can_load && (k == sel); all other bits 0.
REQ-020 Transfer on channel k SHALL occur when in_valid[k] && in_ready[k]; next edge loads out_data = channel k data, out_chan = k, out_valid = 1.
REQ-021 When can_load and selected channel not valid: out_valid <= 0 at next edge if out_ready was consumed; out_data and out_chan hold.
REQ-022 Stall (out_valid && !out_ready && !flush): out_data, out_chan, out_valid SHALL hold stable.
REQ-023 Simultaneous drain and load (out_valid && out_ready && transfer): new word replaces old, out_valid stays 1, no bubble; sustained throughput 1 word/cycle.
REQ-024 flush = 1: next edge out_valid = 0, out_data = 0, out_chan = 0; no transfer that cycle; flush overrides out_ready and in_valid.
REQ-025 in_valid on non-selected channels SHALL have no effect on state.

Reset
REQ-026 rst = 1 at rising edge: out_valid = 0, out_data = 0, out_chan = 0, round-robin pointer = 0.
REQ-027 rst SHALL override flush and any transfer; in_ready SHALL be all 0 while rst = 1.
REQ-028 Reset mid-stall SHALL discard the held word; no output word survives reset.

Configuration
REQ-029 Macro MUXSEL_RR_EN defined: rr_mode port and a SEL_W-bit round-robin pointer ptr exist.
REQ-030 With rr_mode = 1: sel = first k with in_valid[k], searching ptr, ptr+1, ... cyclically, wrapping CHANNELS-1 -> 0; no valid -> no selection; addr ignored.
REQ-031 After a round-robin transfer on channel k, ptr <= k+1, wrapping to 0 at CHANNELS; ptr holds otherwise, including on stall and flush.
REQ-032 rr_mode change SHALL take effect in the same cycle; ptr retained across mode changes.
REQ-033 Macro undefined: no rr_mode port, no pointer; addressed mode only, behaviour per REQ-016..REQ-025.

Verification
REQ-034 After rst, addr=2, in_valid=4'b0100, ch2=32'hDEAD_BEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=DEADBEEF, out_chan=2, out_valid=1.
REQ-035 Held word 32'h1, out_ready=0 for 3 cycles, addr/in_data changing -> out_data stays 1, in_ready=0 throughout; out_ready=1 then loads new word next edge.
REQ-036 CHANNELS=3, addr=3, all valid -> in_ready=0, out_valid stays 0.
REQ-037 out_valid=1, flush=1 with in_valid[addr]=1 -> next cycle out_valid=0, out_data=0, nothing accepted; next word accepted the cycle after.
REQ-038 MUXSEL_RR_EN, rr_mode=1, all 4 valid, out_ready=1 continuously -> out_chan sequence 0,1,2,3,0 back-to-back; in_valid=4'b1010 from ptr=0 -> 1,3,1.
REQ-039 rst asserted while stalled with out_valid=1, ptr=2 -> next cycle out_valid=0, out_data=0, next RR grant from channel 0.
